// File: rtl/fphub_pkg.sv
// -----------------------------------------------------------------------------
// fphub_pkg
// Shared definitions for the HUB floating-point add/sub pipeline.
//   - DEF_M / DEF_E / DEF_TAG_W : default significand, exponent and tag widths
//   - frac_w / sig_w / exp_max / exp_bias : constant functions that derive the
//     format widths from M and E, so each module sizes its own localparams
//   - fphub_t : packed {sign, exp, frac} view of an operand in the default format
// -----------------------------------------------------------------------------
package fphub_pkg;

  localparam int DEF_M     = 24;
  localparam int DEF_E     = 8;
  localparam int DEF_TAG_W = 4;

  // Stored fraction width: the hidden one is not stored.
  function automatic int frac_w(input int m);
    return m - 1;
  endfunction

  // Working significand width: {1, frac, ILSB}.
  function automatic int sig_w(input int m);
    return m + 1;
  endfunction

  // All-ones exponent; reaching it means the result has overflowed.
  function automatic int exp_max(input int e);
    return (1 << e) - 1;
  endfunction

  function automatic int exp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  typedef struct packed {
    logic                 sign;
    logic [DEF_E-1:0]     exp;
    logic [DEF_M-2:0]     frac;
  } fphub_t;

endpackage

// File: rtl/fphub_lzc.sv
// -----------------------------------------------------------------------------
// fphub_lzc
// Combinational leading-zero counter.
//   vec : input vector, W bits
//   lz  : number of zeros above the most significant one; W when vec == 0
// -----------------------------------------------------------------------------
module fphub_lzc #(
  parameter int W  = 28,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] lz
);

  // Scanning upwards lets the highest set bit overwrite every lower one.
  always_comb begin
    lz = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) lz = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fphub_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fphub_addsub_pipe
// Three-stage pipelined HUB floating-point adder/subtractor with valid/ready
// flow control. One operation per cycle, 3-cycle latency without stalls.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; in_ready = !out_valid || out_ready
//   op_sub               : 0 -> Z = X + Y, 1 -> Z = X - Y
//   X, Y                 : HUB operands {sign, exp[E-1:0], frac[M-2:0]}
//   tag_in / tag_out     : opaque tag carried with each operation
//   out_valid / out_ready: result handshake
//   Z                    : HUB result
//   ovf                  : result saturated to the largest finite magnitude
//   zero                 : result is +0 (cancellation, underflow, zero operands)
// Stages: S1 compare/swap, S2 align/add, S3 normalise/truncate.
// -----------------------------------------------------------------------------
module fphub_addsub_pipe
  import fphub_pkg::*;
#(
  parameter int M     = DEF_M,
  parameter int E     = DEF_E,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [E+M-1:0]   X,
  input  logic [E+M-1:0]   Y,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [E+M-1:0]   Z,
  output logic [TAG_W-1:0] tag_out,
  output logic             ovf,
  output logic             zero
);

  localparam int FRAC_W  = frac_w(M);
  localparam int SIG_W   = sig_w(M);
  localparam int EXP_MAX = exp_max(E);
  localparam int XW      = SIG_W + 2;          // significand plus 2 guard bits
  localparam int SUM_W   = XW + 1;             // plus carry-out
  localparam int LZ_W    = $clog2(SUM_W + 1);
  localparam int EXW     = E + 2;              // room for exp+1 and a sign bit

  typedef struct packed {
    logic              sign;
    logic [E-1:0]      exp;
    logic [FRAC_W-1:0] frac;
  } op_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic              sign;
    logic              eff_sub;
    logic              both_zero;
    logic [E-1:0]      exp_a;
    logic [E-1:0]      d;
    logic [SIG_W-1:0]  sig_a;
    logic [SIG_W-1:0]  sig_b;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic              sign;
    logic              both_zero;
    logic [E-1:0]      exp_a;
    logic [SUM_W-1:0]  sum;
  } s2_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic              ovf;
    logic              zero;
    op_t               z;
  } out_t;

  s1_t  s1_d,  s1_q;
  s2_t  s2_d,  s2_q;
  out_t out_d, out_q;

  logic adv;

  // A single advance enable keeps every stage in lock-step: when the output
  // is stalled nothing moves, so the held result and all in-flight ops freeze.
  assign adv      = !out_q.valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // S1: compare magnitudes, order operands so that |A| >= |B|
  // ---------------------------------------------------------------------------
  op_t              x_op, y_op;
  logic             y_sign_eff;
  logic             swap;
  logic [SIG_W-1:0] sig_x, sig_y;

  assign x_op = op_t'(X);
  assign y_op = op_t'(Y);

  always_comb begin
    // NOTE: every variable written here gets a value on every path (the
    // default below first), otherwise synthesis infers a latch.
    s1_d       = '0;
    y_sign_eff = y_op.sign ^ op_sub;
    // Ties keep X as A, so an exact cancellation subtracts equal significands.
    swap       = {y_op.exp, y_op.frac} > {x_op.exp, x_op.frac};
    // A zero exponent encodes zero; the hidden one and ILSB vanish with it.
    sig_x      = (x_op.exp == '0) ? '0 : {1'b1, x_op.frac, 1'b1};
    sig_y      = (y_op.exp == '0) ? '0 : {1'b1, y_op.frac, 1'b1};

    s1_d.valid     = in_valid;
    s1_d.tag       = tag_in;
    s1_d.eff_sub   = x_op.sign ^ y_sign_eff;
    s1_d.both_zero = (x_op.exp == '0) && (y_op.exp == '0);
    if (swap) begin
      s1_d.sign  = y_sign_eff;
      s1_d.exp_a = y_op.exp;
      s1_d.d     = y_op.exp - x_op.exp;
      s1_d.sig_a = sig_y;
      s1_d.sig_b = sig_x;
    end else begin
      s1_d.sign  = x_op.sign;
      s1_d.exp_a = x_op.exp;
      s1_d.d     = x_op.exp - y_op.exp;
      s1_d.sig_a = sig_x;
      s1_d.sig_b = sig_y;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: align B to A and add/subtract (bits shifted out are simply dropped)
  // ---------------------------------------------------------------------------
  logic [XW-1:0] a_ext, b_ext, b_sh;

  always_comb begin
    s2_d  = '0;
    a_ext = {s1_q.sig_a, 2'b00};
    b_ext = {s1_q.sig_b, 2'b00};
    b_sh  = (32'(s1_q.d) >= 32'(XW)) ? '0 : (b_ext >> s1_q.d);

    s2_d.valid     = s1_q.valid;
    s2_d.tag       = s1_q.tag;
    s2_d.sign      = s1_q.sign;
    s2_d.both_zero = s1_q.both_zero;
    s2_d.exp_a     = s1_q.exp_a;
    // |A| >= |B| so the difference never goes negative.
    s2_d.sum       = s1_q.eff_sub ? ({1'b0, a_ext} - {1'b0, b_sh})
                                  : ({1'b0, a_ext} + {1'b0, b_sh});
  end

  // ---------------------------------------------------------------------------
  // S3: normalise so the leading one sits at the carry position, then truncate.
  // With the leading one at bit SUM_W-1 the exponent is exp_a + 1 - lz, which
  // covers both the carry-out case (lz = 0) and any cancellation.
  // ---------------------------------------------------------------------------
  logic [LZ_W-1:0]  lz;
  logic [SUM_W-1:0] norm;
  logic [EXW-1:0]   exp_r;
  logic             underflow;
  logic             overflow;
  logic             unused_norm;

  fphub_lzc #(
    .W  (SUM_W),
    .CW (LZ_W)
  ) u_lzc (
    .vec (s2_q.sum),
    .lz  (lz)
  );

  // The leading one and the bits below the stored fraction are discarded;
  // the result ILSB stands in for them, which makes truncation round-to-nearest.
  assign unused_norm = ^{norm[SUM_W-1], norm[SUM_W-FRAC_W-2:0]};

  always_comb begin
    out_d     = '0;
    norm      = s2_q.sum << lz;
    exp_r     = EXW'(s2_q.exp_a) + EXW'(1) - EXW'(lz);
    underflow = exp_r[EXW-1] || (exp_r == '0);
    overflow  = !underflow && (exp_r >= EXW'(EXP_MAX));

    out_d.valid = s2_q.valid;
    out_d.tag   = s2_q.tag;
    if ((s2_q.sum == '0) || s2_q.both_zero || underflow) begin
      out_d.zero = 1'b1;
    end else if (overflow) begin
      out_d.ovf    = 1'b1;
      out_d.z.sign = s2_q.sign;
      out_d.z.exp  = E'(EXP_MAX - 1);
      out_d.z.frac = '1;
    end else begin
      out_d.z.sign = s2_q.sign;
      out_d.z.exp  = exp_r[E-1:0];
      out_d.z.frac = norm[SUM_W-2 -: FRAC_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: stage data is cleared along with the valids; these are a few
    // flops, not a memory array, so Z/tag/flags come out of reset at zero.
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
    end else if (adv) begin
      // NOTE: non-blocking assignments so every stage samples the value its
      // predecessor held before this edge.
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
    end
  end

  assign out_valid = out_q.valid;
  assign Z         = out_q.z;
  assign tag_out   = out_q.tag;
  assign ovf       = out_q.ovf;
  assign zero      = out_q.zero;

endmodule

// File: tb/tb_fphub_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_fphub_addsub_pipe
// Directed bench for fphub_addsub_pipe (M=24, E=8, TAG_W=4). Inputs are
// driven on the falling edge and outputs sampled 1 ns later, so every value
// seen is stable with respect to the rising edge.
// -----------------------------------------------------------------------------
module tb_fphub_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [31:0] X, Y, Z;
  logic [3:0]  tag_in, tag_out;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fphub_addsub_pipe #(
    .M     (24),
    .E     (8),
    .TAG_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .X         (X),
    .Y         (Y),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .tag_out   (tag_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One isolated operation with exact latency: not valid after 1 and 2
  // rising edges past the transfer, valid after the 3rd.
  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic sub, input logic [3:0] t,
                        input logic [31:0] ez, input logic eovf, input logic ezero);
    @(negedge clk);
    X = x; Y = y; op_sub = sub; tag_in = t; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({name, " in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({name, " lat1"}, out_valid, 1'b0);
    @(negedge clk);
    #1 check({name, " lat2"}, out_valid, 1'b0);
    @(negedge clk);
    #1;
    check({name, " out_valid"}, out_valid, 1'b1);
    check({name, " Z"},         Z,         ez);
    check({name, " tag"},       tag_out,   t);
    check({name, " ovf"},       ovf,       eovf);
    check({name, " zero"},      zero,      ezero);
  endtask

  // Five ops streamed back to back; the consumer stalls from cycle 4 to 11.
  task automatic backpressure();
    logic [31:0] bx [5] = '{32'h40400000, 32'h40A00000, 32'h40400000, 32'h40400000, 32'h00000000};
    logic [31:0] by [5] = '{32'h40A00000, 32'h40400000, 32'h40A00000, 32'h40400000, 32'h40400000};
    logic        bs [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] bz [5] = '{32'h41000000, 32'h40000000, 32'hC0000000, 32'h00000000, 32'h40400000};
    logic        bzf[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    logic        held_v = 1'b0;
    logic [31:0] held_z = '0;
    logic [3:0]  held_t = '0;
    while (got < 5 && cyc < 60) begin
      @(negedge clk);
      out_ready = (cyc < 4) || (cyc >= 12);
      if (sent < 5) begin
        in_valid = 1'b1; X = bx[sent]; Y = by[sent]; op_sub = bs[sent];
        tag_in = 4'(4'hA + sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        check("bp in_ready low", in_ready, 1'b0);
        if (held_v) begin
          check("bp hold Z",   Z,       held_z);
          check("bp hold tag", tag_out, held_t);
        end
        held_v = 1'b1; held_z = Z; held_t = tag_out;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        check("bp Z",    Z,       bz[got]);
        check("bp tag",  tag_out, 4'(4'hA + got));
        check("bp zero", zero,    bzf[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("bp results received", got, 5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 check("bp no extra result", out_valid, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    X = '0; Y = '0; tag_in = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset Z",         Z,         32'h0);
    check("reset tag_out",   tag_out,   4'h0);
    check("reset ovf",       ovf,       1'b0);
    check("reset zero",      zero,      1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset in_ready", in_ready, 1'b1);

    //     name          X             Y             sub   tag   Z             ovf   zero
    run_op("add",        32'h40400000, 32'h40A00000, 1'b0, 4'h3, 32'h41000000, 1'b0, 1'b0);
    run_op("sub",        32'h40A00000, 32'h40400000, 1'b1, 4'h5, 32'h40000000, 1'b0, 1'b0);
    run_op("sub swap",   32'h40400000, 32'h40A00000, 1'b1, 4'h6, 32'hC0000000, 1'b0, 1'b0);
    run_op("cancel",     32'h40400000, 32'h40400000, 1'b1, 4'h7, 32'h00000000, 1'b0, 1'b1);
    run_op("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'h8, 32'h7F7FFFFF, 1'b1, 1'b0);
    run_op("zero op",    32'h00000000, 32'h40400000, 1'b0, 4'h9, 32'h40400000, 1'b0, 1'b0);
    run_op("both zero",  32'h00000000, 32'h80000000, 1'b0, 4'hB, 32'h00000000, 1'b0, 1'b1);
    run_op("far align",  32'h40400000, 32'h00800000, 1'b0, 4'hC, 32'h40400000, 1'b0, 1'b0);
    run_op("underflow",  32'h00800000, 32'h00800001, 1'b1, 4'hD, 32'h00000000, 1'b0, 1'b1);

    backpressure();

    // Reset with three ops in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; X = 32'h40400000; Y = 32'h40A00000; op_sub = 1'b0; tag_in = 4'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("rst pre out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst Z",         Z,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst release out_valid", out_valid, 1'b0);
    repeat (4) begin
      @(negedge clk);
      #1 check("rst no stale result", out_valid, 1'b0);
    end
    run_op("after reset", 32'h40A00000, 32'h40400000, 1'b0, 4'hE, 32'h41000000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
